// File: rtl/cursor_move_pacer.sv
// cursor_move_pacer: synchronises, debounces and edge-masks the direction keys,
// then paces them into single-cycle move strobes with a press/delay/repeat cadence.
module cursor_move_pacer #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000,
  parameter int X_MAX           = 159,
  parameter int Y_MAX           = 119
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic [3:0] keys_n,
  input  logic [7:0] curX,
  input  logic [6:0] curY,
  output logic [3:0] directions,
  output logic       enMove
);

  localparam int              DW          = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DW-1:0]   DLAST       = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [24:0]     DELAY_LOAD  = 25'(REPEAT_DELAY - 1);
  localparam logic [24:0]     PERIOD_LOAD = 25'(REPEAT_PERIOD - 1);
  localparam logic [7:0]      XLIM        = 8'(X_MAX);
  localparam logic [6:0]      YLIM        = 7'(Y_MAX);

  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_t;

  state_t        state;
  logic [3:0]    sync1, sync2;
  logic [3:0]    cand, stable, eff;
  logic [DW-1:0] dcnt;
  logic          chg;
  logic [24:0]   timer;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      sync1 <= 4'b0000;
      sync2 <= 4'b0000;
    end else begin
      sync1 <= ~keys_n;
      sync2 <= sync1;
    end
  end

  // A vector is accepted only after it has been seen unchanged for DEBOUNCE_CYCLES samples.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      cand   <= 4'b0000;
      dcnt   <= '0;
      stable <= 4'b0000;
      chg    <= 1'b0;
    end else begin
      chg <= 1'b0;
      if (sync2 != cand) begin
        cand <= sync2;
        dcnt <= '0;
      end else if (dcnt != DLAST) begin
        dcnt <= dcnt + 1'b1;
      end
      if (dcnt == DLAST && stable != cand) begin
        stable <= cand;
        chg    <= 1'b1;
      end
    end
  end

  always_comb begin
    eff = stable;
    if (stable[3] && stable[1]) begin
      eff[3] = 1'b0;
      eff[1] = 1'b0;
    end
    if (stable[2] && stable[0]) begin
      eff[2] = 1'b0;
      eff[0] = 1'b0;
    end
    if (curX == 8'd0)  eff[3] = 1'b0;
    if (curX >= XLIM)  eff[1] = 1'b0;
    if (curY == 7'd0)  eff[2] = 1'b0;
    if (curY >= YLIM)  eff[0] = 1'b0;
  end

  // A key-set change restarts the long delay so a new combination feels like a fresh press.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state      <= IDLE;
      timer      <= '0;
      enMove     <= 1'b0;
      directions <= 4'b0000;
    end else begin
      enMove <= 1'b0;
      case (state)
        IDLE: begin
          if (eff != 4'b0000) begin
            enMove     <= 1'b1;
            directions <= eff;
            timer      <= DELAY_LOAD;
            state      <= DELAY;
          end
        end
        DELAY: begin
          if (eff == 4'b0000) begin
            directions <= 4'b0000;
            state      <= IDLE;
          end else if (chg) begin
            enMove     <= 1'b1;
            directions <= eff;
            timer      <= DELAY_LOAD;
          end else if (timer == 25'd0) begin
            enMove     <= 1'b1;
            directions <= eff;
            timer      <= PERIOD_LOAD;
            state      <= REPEAT;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        REPEAT: begin
          if (eff == 4'b0000) begin
            directions <= 4'b0000;
            state      <= IDLE;
          end else if (chg) begin
            enMove     <= 1'b1;
            directions <= eff;
            timer      <= DELAY_LOAD;
            state      <= DELAY;
          end else if (timer == 25'd0) begin
            enMove     <= 1'b1;
            directions <= eff;
            timer      <= PERIOD_LOAD;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cursor_move_pacer.sv
// Bench for cursor_move_pacer: directed key scenarios plus random key traffic,
// compared every cycle against a timing model derived from the key waveform.
module tb_cursor_move_pacer;

  localparam int DC = 4;
  localparam int RD = 20;
  localparam int RP = 8;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic [3:0] keys_n = 4'hF;
  logic [7:0] curX;
  logic [6:0] curY;
  logic [3:0] directions;
  logic       enMove;

  logic       setPos = 1'b0;
  logic [7:0] setX = 8'd0;
  logic [6:0] setY = 7'd0;

  int nCompared = 0;
  int nMismatch = 0;
  int strobeCount = 0;

  cursor_move_pacer #(
    .DEBOUNCE_CYCLES(DC),
    .REPEAT_DELAY(RD),
    .REPEAT_PERIOD(RP),
    .X_MAX(159),
    .Y_MAX(119)
  ) dut (
    .clock(clock),
    .resetn(resetn),
    .keys_n(keys_n),
    .curX(curX),
    .curY(curY),
    .directions(directions),
    .enMove(enMove)
  );

  always #5 clock = ~clock;

  // Movement stage stand-in: position follows each strobe one cycle later.
  always @(posedge clock) begin
    if (setPos) begin
      curX <= setX;
      curY <= setY;
    end else if (enMove === 1'b1) begin
      curX <= curX - {7'd0, directions[3]} + {7'd0, directions[1]};
      curY <= curY - {6'd0, directions[2]} + {6'd0, directions[0]};
    end
  end

  always @(posedge clock) begin
    if (enMove === 1'b1) strobeCount <= strobeCount + 1;
  end

  function automatic logic [3:0] maskKeys(input logic [3:0] v, input logic [7:0] x, input logic [6:0] y);
    logic [3:0] m;
    m = v;
    if (v[3] && v[1]) begin m[3] = 1'b0; m[1] = 1'b0; end
    if (v[2] && v[0]) begin m[2] = 1'b0; m[0] = 1'b0; end
    if (x == 8'd0)   m[3] = 1'b0;
    if (x >= 8'd159) m[1] = 1'b0;
    if (y == 7'd0)   m[2] = 1'b0;
    if (y >= 7'd119) m[0] = 1'b0;
    return m;
  endfunction

  // Reference: a sample run of DC equal values is accepted DC+2 edges after its first
  // sample; moves are scheduled by absolute edge numbers (press + RD, then every RP).
  logic [3:0]  sh [0:DC+3];
  logic [3:0]  stableM = 4'd0;
  logic        chgM = 1'b0;
  logic        activeM = 1'b0;
  logic        expEn = 1'b0;
  logic [3:0]  expDir = 4'd0;
  int unsigned edgeNo = 0;
  int unsigned dueEdge = 0;

  always @(posedge clock) begin : model
    logic [3:0] effM;
    logic [3:0] newStable;
    logic       runOk;
    edgeNo++;
    if (!resetn) begin
      for (int i = 0; i < DC + 4; i++) sh[i] = 4'd0;
      stableM = 4'd0;
      chgM    = 1'b0;
      activeM = 1'b0;
      expEn   = 1'b0;
      expDir  = 4'd0;
    end else begin
      effM  = maskKeys(stableM, curX, curY);
      expEn = 1'b0;
      if (!activeM) begin
        if (effM != 4'd0) begin
          expEn = 1'b1; expDir = effM; activeM = 1'b1; dueEdge = edgeNo + RD;
        end
      end else if (effM == 4'd0) begin
        activeM = 1'b0; expDir = 4'd0;
      end else if (chgM) begin
        expEn = 1'b1; expDir = effM; dueEdge = edgeNo + RD;
      end else if (edgeNo == dueEdge) begin
        expEn = 1'b1; expDir = effM; dueEdge = edgeNo + RP;
      end
      for (int i = DC + 3; i > 0; i--) sh[i] = sh[i-1];
      sh[0] = ~keys_n;
      runOk = 1'b1;
      for (int i = 3; i < 3 + DC; i++) if (sh[i] != sh[3]) runOk = 1'b0;
      newStable = runOk ? sh[3] : stableM;
      chgM      = (newStable != stableM);
      stableM   = newStable;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    nCompared++;
    if (got !== want) begin
      nMismatch++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, want, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
    checkOutput("enMove", 32'(enMove), 32'(expEn));
    checkOutput("directions", 32'(directions), 32'(expDir));
  endtask

  task automatic applyStimulus(input logic [3:0] k, input int cycles);
    keys_n = k;
    repeat (cycles) tick();
  endtask

  task automatic setPosition(input logic [7:0] x, input logic [6:0] y);
    setX = x;
    setY = y;
    setPos = 1'b1;
    tick();
    setPos = 1'b0;
  endtask

  function automatic logic [7:0] pickX();
    case ($urandom_range(0, 4))
      0: return 8'd0;
      1: return 8'd1;
      2: return 8'd158;
      3: return 8'd159;
      default: return 8'($urandom_range(0, 159));
    endcase
  endfunction

  function automatic logic [6:0] pickY();
    case ($urandom_range(0, 4))
      0: return 7'd0;
      1: return 7'd1;
      2: return 7'd118;
      3: return 7'd119;
      default: return 7'($urandom_range(0, 119));
    endcase
  endfunction

  initial begin
    int c0;
    int r;
    int holdLen;
    logic [3:0] k;

    @(negedge clock);
    resetn = 1'b0;
    setX = 8'd80;
    setY = 7'd60;
    setPos = 1'b1;
    repeat (3) tick();
    setPos = 1'b0;
    checkOutput("rstEnMove", 32'(enMove), 32'd0);
    checkOutput("rstDirections", 32'(directions), 32'd0);
    resetn = 1'b1;
    applyStimulus(4'hF, 8);

    $display("[TB] single tap");
    c0 = strobeCount;
    applyStimulus(4'b0111, 15);
    applyStimulus(4'hF, 12);
    checkOutput("tapCount", 32'(strobeCount - c0), 32'd1);
    checkOutput("tapX", 32'(curX), 32'd79);
    checkOutput("tapDirIdle", 32'(directions), 32'd0);

    $display("[TB] auto-repeat");
    setPosition(8'd80, 7'd60);
    c0 = strobeCount;
    applyStimulus(4'b1101, 60);
    applyStimulus(4'hF, 12);
    checkOutput("repeatCount", 32'(strobeCount - c0), 32'd6);
    checkOutput("repeatX", 32'(curX), 32'd86);

    $display("[TB] bounce reject");
    c0 = strobeCount;
    for (int i = 0; i < 10; i++) applyStimulus((i % 2 == 0) ? 4'b1011 : 4'hF, 3);
    checkOutput("bounceCount", 32'(strobeCount - c0), 32'd0);
    applyStimulus(4'b1011, 12);
    applyStimulus(4'hF, 12);
    checkOutput("bounceHeldCount", 32'(strobeCount - c0), 32'd1);
    checkOutput("bounceY", 32'(curY), 32'd59);

    $display("[TB] edge clamp");
    setPosition(8'd158, 7'd60);
    c0 = strobeCount;
    applyStimulus(4'b1101, 30);
    checkOutput("clampXDir", 32'(directions), 32'd0);
    applyStimulus(4'hF, 12);
    checkOutput("clampXCount", 32'(strobeCount - c0), 32'd1);
    checkOutput("clampX", 32'(curX), 32'd159);
    setPosition(8'd80, 7'd1);
    c0 = strobeCount;
    applyStimulus(4'b1011, 30);
    checkOutput("clampYDir", 32'(directions), 32'd0);
    applyStimulus(4'hF, 12);
    checkOutput("clampYCount", 32'(strobeCount - c0), 32'd1);
    checkOutput("clampY", 32'(curY), 32'd0);

    $display("[TB] combination change and conflict");
    setPosition(8'd80, 7'd60);
    c0 = strobeCount;
    applyStimulus(4'b0111, 12);
    applyStimulus(4'b0011, 30);
    applyStimulus(4'hF, 12);
    checkOutput("comboCount", 32'(strobeCount - c0), 32'd4);
    checkOutput("comboX", 32'(curX), 32'd76);
    checkOutput("comboY", 32'(curY), 32'd57);
    c0 = strobeCount;
    applyStimulus(4'b0101, 30);
    applyStimulus(4'hF, 12);
    checkOutput("conflictCount", 32'(strobeCount - c0), 32'd0);

    $display("[TB] reset mid-repeat");
    setPosition(8'd80, 7'd60);
    c0 = strobeCount;
    applyStimulus(4'b1101, 40);
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    checkOutput("rstMidEnMove", 32'(enMove), 32'd0);
    checkOutput("rstMidDirections", 32'(directions), 32'd0);
    applyStimulus(4'b1101, 20);
    applyStimulus(4'hF, 12);
    checkOutput("rstMidCount", 32'(strobeCount - c0), 32'd4);
    checkOutput("rstMidX", 32'(curX), 32'd84);

    $display("[TB] random traffic");
    for (int s = 0; s < 60; s++) begin
      r = $urandom_range(0, 9);
      if (r == 0) begin
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
      end else if (r < 4) begin
        setPosition(pickX(), pickY());
      end
      k = 4'($urandom_range(0, 15));
      holdLen = $urandom_range(1, 40);
      applyStimulus(k, holdLen);
    end
    applyStimulus(4'hF, 12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

endmodule
